serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: accepts two WIDTH-bit operands, computes a - b LSB-first at one bit per clock, and returns the difference plus a final borrow.
- Bit datapath is a full subtractor built from two half_subtractor cells and a registered borrow.
- Sits beside the existing combinational half_adder as the area-cheap arithmetic path: one bit-cell, shift registers, small FSM.
- Valid/ready handshake on both input and output.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend, sampled only on accept
- b  input  WIDTH  subtrahend, sampled only on accept
- out_valid  output  1  diff/borrow valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a - b) mod 2^WIDTH
- borrow  output  1  1 iff a < b (unsigned)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; shift registers, bit counter, borrow register, diff and out_valid all cleared to 0.
  - in_ready=1, since it is decoded from state==IDLE.
  - No accept occurs on any edge while rst_n is low.
- States IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept = in_valid & in_ready at a rising edge: latch a into sa and b into sb, clear the borrow register, clear the counter, go to RUN.
- RUN (in_ready=0, out_valid=0), each cycle:
  - Bit cell: d = sa[0]^sb[0]^bw; bw_next = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&bw).
  - Cell structure: half_subtractor(sa[0],sb[0]) -> (d1,b1); half_subtractor(d1,bw) -> (d,b2); bw_next = b1|b2.
  - sa and sb shift right by 1; d shifts into the diff register at the MSB (diff = {d, diff[WIDTH-1:1]}).
  - Counter increments. When counter==WIDTH-1, the edge moves to DONE and registers the final bw_next on borrow.
  - Exactly WIDTH RUN cycles.
- DONE:
  - out_valid=1; diff and borrow held stable.
  - out_ready=1 at an edge returns to IDLE. out_valid drops, diff/borrow keep their value until the next RUN overwrites diff.
- Latency: out_valid rises WIDTH clock edges after the accepting edge.
  - Minimum issue interval is WIDTH+2 cycles: accept, WIDTH RUN, DONE with out_ready=1.
  - No accept in the same cycle as result handoff (in_ready=0 in DONE).
- Boundaries:
  - in_valid while in_ready=0 is ignored; a/b may change freely.
  - out_ready while out_valid=0 has no effect.
  - a==b gives diff=0, borrow=0.
  - a=0, b=2^WIDTH-1 gives diff=1, borrow=1.
  - Reset asserted mid-RUN or in DONE aborts the operation; no partial result is ever presented.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.

Decomposition:
- Shared package/header:
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2 as localparams; 2'd3 is illegal and returns to IDLE.
  - Counter width CNT_W = clog2(WIDTH).
- Sub-module half_subtractor (ports diff, bout, a, b; diff=a^b, bout=~a&b), gate-primitive style matching half_adder; instantiated twice.

Test Plan:
- WIDTH=8, accept a=0x35 b=0x12, out_ready=1 -> out_valid exactly 8 edges after accept; diff=0x23, borrow=0; in_ready=0 from accept until the DONE handoff.
- a=0x12 b=0x35 -> diff=0xDD, borrow=1. a=0x00 b=0x01 -> diff=0xFF, borrow=1. a=0xFF b=0xFF -> diff=0x00, borrow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with a=0x01 b=0x01 -> diff/borrow stable, out_valid=1, in_ready=0, new operands not latched. Release -> IDLE, then next accept yields diff=0x00.
- Reset mid-RUN: pulse rst_n low after 4 RUN cycles -> immediately out_valid=0, diff=0, borrow=0, in_ready=1. Next operation a=0x80 b=0x01 -> diff=0x7F, borrow=0.
- Streaming: in_valid=1 and out_ready=1 permanently -> one result every 10 cycles at WIDTH=8. 1000 random operand pairs match the (a-b) mod 256 and a<b reference model; repeat with WIDTH=2 and WIDTH=32.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared state encodings and sizing helper for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // 2'd3 is left unnamed on purpose; the FSM treats it as illegal and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// One-bit half subtractor in gate-primitive form, the borrow-side twin of half_adder.
module half_subtractor (
    output wire diff,
    output wire bout,
    input  wire a,
    input  wire b
);

    wire a_n;

    xor u_xor (diff, a, b);
    not u_not (a_n, a);
    and u_and (bout, a_n, b);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, LSB first, one bit per clock, valid/ready on both sides.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CNT_W-1:0] cnt;
    logic             bw;

    logic d1;
    logic b1;
    logic d;
    logic b2;
    logic bw_next;

    // Full subtractor from two half cells; the running borrow feeds the second cell.
    half_subtractor u_hs_ab (
        .diff (d1),
        .bout (b1),
        .a    (sa[0]),
        .b    (sb[0])
    );

    half_subtractor u_hs_bw (
        .diff (d),
        .bout (b2),
        .a    (d1),
        .b    (bw)
    );

    assign bw_next   = b1 | b2;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            cnt    <= '0;
            bw     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa    <= a;
                        sb    <= b;
                        bw    <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    diff <= {d, diff[WIDTH-1:1]};
                    bw   <= bw_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        borrow <= bw_next;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
